// File: rtl/tappy_pkg.sv
// tappy_pkg: shared types and frame-length helper for the serial word receiver.
package tappy_pkg;
    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;
    typedef enum logic {EDGE_RISE, EDGE_FALL} edge_t;
    function automatic int frame_bits(input int width, input parity_t parity);
        return width + ((parity == PAR_NONE) ? 0 : 1);
    endfunction
endpackage

// File: rtl/word_fifo.sv
// word_fifo: show-ahead DEPTH x WIDTH sync FIFO with valid/ready head and overflow pulse.
module word_fifo
    import tappy_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] word,
    output logic             valid,
    input  logic             ready,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic pop, full, wr;
    assign pop = valid && ready;
    assign full = count == (AW+1)'(DEPTH);
    assign wr = push && (!full || pop);
    assign valid = count != '0;
    assign word = mem[rd_ptr];
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr) - (AW+1)'(pop);
            overflow <= push && full && !pop;
        end
    end
endmodule

// File: rtl/parse_stream.sv
// parse_stream: oversampling serial-word receiver; syncs clk/dat into sysclk, assembles
// parity-checked words and queues them behind a valid/ready FIFO.
module parse_stream
    import tappy_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MSB_FIRST   = 0,
    parameter int SAMPLE_EDGE = 0,
    parameter int PARITY      = 0,
    parameter int GAP_CYCLES  = 64,
    parameter int DEPTH       = 4
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic             clk,
    input  logic             dat,
    output logic [WIDTH-1:0] word,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             overflow,
    output logic             frame_err,
    output logic             parity_err
);
    localparam parity_t PAR = parity_t'(PARITY);
    localparam int FRAME = frame_bits(WIDTH, PAR);
    localparam int BW = $clog2(FRAME + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    logic [2:0] clk_s;
    logic [1:0] dat_s;
    logic [WIDTH-1:0] shreg, shifted, push_word;
    logic [BW-1:0] bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic par_acc, push, sample, bit_in, last, timeout, par_ok;
    assign sample = (edge_t'(SAMPLE_EDGE) == EDGE_FALL) ? (clk_s[2] && !clk_s[1])
                                                         : (clk_s[1] && !clk_s[2]);
    assign bit_in = dat_s[1];
    assign busy = bit_cnt != '0;
    assign last = bit_cnt == BW'(FRAME - 1);
    assign timeout = (GAP_CYCLES != 0) && busy && gap_cnt == GW'(GAP_CYCLES - 1);
    assign par_ok = (PAR == PAR_NONE) || ((par_acc ^ bit_in) == (PAR == PAR_ODD));
    // Both shift directions keep the first bit received at the configured end of the word.
    assign shifted = (MSB_FIRST != 0) ? WIDTH'({shreg, bit_in}) : WIDTH'({bit_in, shreg} >> 1);
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s <= '0;
            dat_s <= '0;
            shreg <= '0;
            push_word <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            par_acc <= 1'b0;
            push <= 1'b0;
            frame_err <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            clk_s <= {clk_s[1:0], clk};
            dat_s <= {dat_s[0], dat};
            push <= sample && last && par_ok;
            parity_err <= sample && last && !par_ok;
            frame_err <= !sample && timeout;
            if (sample) begin
                if (bit_cnt < BW'(WIDTH)) shreg <= shifted;
                push_word <= (PAR == PAR_NONE) ? shifted : shreg;
                par_acc <= last ? 1'b0 : par_acc ^ bit_in;
                bit_cnt <= last ? '0 : bit_cnt + BW'(1);
                gap_cnt <= '0;
            end else if (timeout) begin
                bit_cnt <= '0;
                par_acc <= 1'b0;
                gap_cnt <= '0;
            end else begin
                gap_cnt <= busy ? gap_cnt + GW'(1) : '0;
            end
        end
    end
    word_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo (
        .sysclk(sysclk),
        .reset_n(reset_n),
        .push(push),
        .din(push_word),
        .word(word),
        .valid(valid),
        .ready(ready),
        .overflow(overflow)
    );
endmodule

// File: tb/tb_parse_stream.sv
// tb_parse_stream: three configurations of parse_stream checked every cycle against a
// bit-queue/word-queue model, plus directed scenarios with hand-computed expectations.
module tb_parse_stream;
    logic sysclk = 1'b0;
    logic reset_n = 1'b0;
    logic clk_l [3] = '{default: 1'b0};
    logic dat_l [3] = '{default: 1'b0};
    logic ready_l [3] = '{default: 1'b0};
    logic [31:0] word_l [3];
    logic valid_l [3];
    logic busy_l [3];
    int checks = 0, errors = 0, cyc = 0, last_rise = 0;
    logic rnd_on = 1'b0;
    logic [31:0] got_q [$];

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    function automatic int cw(input int i); return i == 0 ? 8 : i == 1 ? 12 : 5; endfunction
    function automatic int cm(input int i); return i == 1 ? 1 : 0; endfunction
    function automatic int cs(input int i); return i == 2 ? 1 : 0; endfunction
    function automatic int cp(input int i); return i == 0 ? 0 : i == 1 ? 2 : 1; endfunction
    function automatic int cg(input int i); return i == 2 ? 20 : 64; endfunction
    function automatic int cd(input int i); return i == 2 ? 2 : 4; endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h at cycle %0d", name, idx, got, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int W = cw(g);
        localparam int FB = W + (cp(g) != 0 ? 1 : 0);
        logic [W-1:0] word;
        logic valid, busy, ovf, ferr, perr;
        parse_stream #(.WIDTH(W), .MSB_FIRST(cm(g)), .SAMPLE_EDGE(cs(g)), .PARITY(cp(g)),
                       .GAP_CYCLES(cg(g)), .DEPTH(cd(g))) dut (
            .sysclk(sysclk), .reset_n(reset_n), .clk(clk_l[g]), .dat(dat_l[g]),
            .word(word), .valid(valid), .ready(ready_l[g]), .busy(busy),
            .overflow(ovf), .frame_err(ferr), .parity_err(perr));
        assign word_l[g] = 32'(word);
        assign valid_l[g] = valid;
        assign busy_l[g] = busy;
        logic [W-1:0] mq [$], pend_w [$];
        int pend_due [$], ev_due [$];
        logic ev_bit [$], bits [$];
        logic [W-1:0] data, w;
        logic prev_clk, prev_valid, m_ovf, m_ferr, m_perr, do_pop, have, ok, b;
        int since, edge_n, ones, n_pop, n_ovf, n_ferr, n_perr, vrise_cyc, ferr_cyc;
        logic [31:0] vrise_word;
        initial begin
            prev_clk = 0; prev_valid = 0; since = 0; edge_n = 0;
            n_pop = 0; n_ovf = 0; n_ferr = 0; n_perr = 0; vrise_cyc = 0; ferr_cyc = 0; vrise_word = 0;
            m_ovf = 0; m_ferr = 0; m_perr = 0;
            forever begin
                @(posedge sysclk);
                edge_n++;
                if (!reset_n) begin
                    mq.delete(); pend_w.delete(); pend_due.delete();
                    ev_due.delete(); ev_bit.delete(); bits.delete();
                    since = 0; prev_clk = 0; m_ovf = 0; m_ferr = 0; m_perr = 0;
                end else begin
                    // word lands in the FIFO 3 edges after the final transition is first seen
                    do_pop = mq.size() != 0 && ready_l[g];
                    have = pend_due.size() != 0 && pend_due[0] == edge_n;
                    m_ovf = have && mq.size() == cd(g) && !do_pop;
                    if (do_pop) void'(mq.pop_front());
                    if (have) begin
                        w = pend_w.pop_front();
                        void'(pend_due.pop_front());
                        if (!m_ovf) mq.push_back(w);
                    end
                    m_ferr = 0; m_perr = 0;
                    if (ev_due.size() != 0 && ev_due[0] == edge_n) begin
                        void'(ev_due.pop_front());
                        b = ev_bit.pop_front();
                        bits.push_back(b);
                        since = 0;
                        if (bits.size() == FB) begin
                            data = '0; ones = 0;
                            for (int k = 0; k < W; k++) begin
                                if (cm(g) != 0) data[W-1-k] = bits[k]; else data[k] = bits[k];
                                ones += int'(bits[k]);
                            end
                            ok = cp(g) == 0 || ((ones + int'(bits[W])) % 2 == (cp(g) == 2 ? 1 : 0));
                            if (ok) begin pend_w.push_back(data); pend_due.push_back(edge_n + 1); end
                            else m_perr = 1;
                            bits.delete();
                        end
                    end else if (bits.size() != 0) begin
                        since++;
                        if (since == cg(g)) begin bits.delete(); since = 0; m_ferr = 1; end
                    end else since = 0;
                    if (clk_l[g] !== prev_clk) begin
                        if ((cs(g) == 0) == (clk_l[g] == 1'b1)) begin
                            ev_due.push_back(edge_n + 2);
                            ev_bit.push_back(dat_l[g]);
                        end
                        prev_clk = clk_l[g];
                    end
                end
                #1;
                check("valid", g, 32'(valid), 32'(mq.size() != 0));
                if (mq.size() != 0) check("word", g, 32'(word), 32'(mq[0]));
                check("busy", g, 32'(busy), 32'(bits.size() != 0));
                check("overflow", g, 32'(ovf), 32'(m_ovf));
                check("frame_err", g, 32'(ferr), 32'(m_ferr));
                check("parity_err", g, 32'(perr), 32'(m_perr));
                if (valid && !prev_valid) begin vrise_cyc = cyc; vrise_word = 32'(word); end
                prev_valid = valid;
                n_pop += int'(valid && ready_l[g]);
                n_ovf += int'(ovf);
                n_perr += int'(perr);
                n_ferr += int'(ferr);
                if (ferr) ferr_cyc = cyc;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic send_bit(input int i, input logic bv, input int h);
        dat_l[i] = bv;
        wait_cyc(h / 2);
        clk_l[i] = 1'b1;
        last_rise = cyc;
        wait_cyc(h);
        clk_l[i] = 1'b0;
        wait_cyc(h / 2);
    endtask

    task automatic send_word(input int i, input logic [31:0] wv, input logic bad, input int nbits, input int h);
        int wd = cw(i);
        int ones = 0;
        logic bv;
        for (int k = 0; k < wd && k < nbits; k++) begin
            bv = (cm(i) != 0) ? wv[wd-1-k] : wv[k];
            ones += int'(bv);
            send_bit(i, bv, h);
        end
        if (cp(i) != 0 && nbits > wd) send_bit(i, logic'((ones + (cp(i) == 2 ? 1 : 0)) % 2) ^ bad, h);
    endtask

    task automatic drain(input int i, input int n);
        got_q.delete();
        ready_l[i] = 1'b1;
        for (int t = 0; t < 200 && got_q.size() < n; t++) begin
            if (valid_l[i]) got_q.push_back(word_l[i]);
            @(negedge sysclk);
        end
        ready_l[i] = 1'b0;
        wait_cyc(1);
        check("drain_count", i, got_q.size(), n);
    endtask

    task automatic rand_run(input int i);
        int nb, h;
        for (int f = 0; f < 30; f++) begin
            h = 2 * $urandom_range(1, 3);
            nb = ($urandom_range(0, 9) == 0) ? $urandom_range(1, cw(i) - 1) : 99;
            send_word(i, $urandom, $urandom_range(0, 7) == 0, nb, h);
            wait_cyc(nb == 99 ? $urandom_range(0, 8) : cg(i) + 10);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, r;
        wait_cyc(3);
        for (int i = 0; i < 3; i++) begin
            check("reset_valid", i, 32'(valid_l[i]), 0);
            check("reset_word", i, word_l[i], 0);
            check("reset_busy", i, 32'(busy_l[i]), 0);
        end
        reset_n = 1'b1;
        wait_cyc(2);
        // 1: 0xA5 LSB-first, valid 3 edges after the last rise reaches the first sync flop
        ready_l[0] = 1'b1;
        base = inst[0].n_pop;
        send_word(0, 32'hA5, 1'b0, 99, 4);
        r = last_rise;
        wait_cyc(10);
        check("t1_latency", 0, inst[0].vrise_cyc - r, 4);
        check("t1_word", 0, inst[0].vrise_word, 32'hA5);
        check("t1_beats", 0, inst[0].n_pop - base, 1);
        // 2: MSB-first 12-bit odd parity, good then flipped parity bit
        ready_l[1] = 1'b1;
        base = inst[1].n_perr;
        send_word(1, 32'h3C1, 1'b0, 99, 4);
        wait_cyc(10);
        check("t2_word", 1, inst[1].vrise_word, 32'h3C1);
        r = inst[1].n_pop;
        send_word(1, 32'h3C1, 1'b1, 99, 4);
        wait_cyc(10);
        check("t2_perr", 1, inst[1].n_perr - base, 1);
        check("t2_novalid", 1, inst[1].n_pop - r, 0);
        // 3: five words into a four-deep FIFO with ready low
        ready_l[0] = 1'b0;
        base = inst[0].n_ovf;
        for (int v = 1; v <= 5; v++) send_word(0, 32'(v), 1'b0, 99, 2);
        wait_cyc(10);
        check("t3_overflow", 0, inst[0].n_ovf - base, 1);
        drain(0, 4);
        for (int k = 0; k < 4 && k < got_q.size(); k++) check("t3_order", 0, got_q[k], 32'(k + 1));
        check("t3_empty", 0, 32'(valid_l[0]), 0);
        // 4: three bits then silence -> frame_err 64 cycles after the last bit is taken
        ready_l[0] = 1'b1;
        base = inst[0].n_ferr;
        send_word(0, 32'h7, 1'b0, 3, 4);
        r = last_rise;
        wait_cyc(80);
        check("t4_ferr_count", 0, inst[0].n_ferr - base, 1);
        check("t4_ferr_time", 0, inst[0].ferr_cyc - r, 67);
        check("t4_busy", 0, 32'(busy_l[0]), 0);
        send_word(0, 32'h5A, 1'b0, 99, 4);
        wait_cyc(10);
        check("t4_word", 0, inst[0].vrise_word, 32'h5A);
        // 5: full FIFO, pop in the same cycle the fifth word lands
        ready_l[0] = 1'b0;
        for (int v = 1; v <= 4; v++) send_word(0, 32'(v), 1'b0, 99, 2);
        wait_cyc(10);
        base = inst[0].n_ovf;
        send_word(0, 32'h5, 1'b0, 99, 2);
        ready_l[0] = 1'b1;
        wait_cyc(1);
        ready_l[0] = 1'b0;
        wait_cyc(10);
        check("t5_no_overflow", 0, inst[0].n_ovf - base, 0);
        drain(0, 4);
        for (int k = 0; k < 4 && k < got_q.size(); k++) check("t5_order", 0, got_q[k], 32'(k + 2));
        // 6: reset mid-frame with a word queued
        send_word(0, 32'h77, 1'b0, 99, 4);
        wait_cyc(10);
        send_word(0, 32'hFF, 1'b0, 4, 4);
        reset_n = 1'b0;
        #1;
        check("t6_valid", 0, 32'(valid_l[0]), 0);
        check("t6_word", 0, word_l[0], 0);
        check("t6_busy", 0, 32'(busy_l[0]), 0);
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(2);
        send_word(0, 32'hC3, 1'b0, 99, 4);
        wait_cyc(10);
        drain(0, 1);
        if (got_q.size() > 0) check("t6_word_after", 0, got_q[0], 32'hC3);
        // randomized traffic on all three configurations
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(negedge sysclk);
                for (int i = 0; i < 3; i++) ready_l[i] = $urandom_range(0, 3) != 0;
            end
        join_none
        fork
            rand_run(0);
            rand_run(1);
            rand_run(2);
        join
        rnd_on = 1'b0;
        wait_cyc(2);
        for (int i = 0; i < 3; i++) ready_l[i] = 1'b1;
        wait_cyc(30);
        for (int i = 0; i < 3; i++) check("final_empty", i, 32'(valid_l[i]), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
